// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: 2**REG_AW x DATA_W register file, pending scoreboard, registered ALU bundle.
// Optional macro WB_BYPASS_EN forwards a same-cycle write-back into captured operands and hazard check.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] out_func,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);
  localparam int NREG = 1 << REG_AW;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
  } iss_t;

  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [NREG-1:0]             pend;
  iss_t                        iss_q, iss_d;
  logic                        vld_q;
  logic                        wb_act, accept, haz;
  logic                        byp_rs, byp_rt, byp_rd;
  logic                        busy_rs, busy_rt, busy_rd;

  assign wb_act = wb_en && (wb_rd != '0);

`ifdef WB_BYPASS_EN
  assign byp_rs = wb_act && (wb_rd == in_rs);
  assign byp_rt = wb_act && (wb_rd == in_rt);
  assign byp_rd = wb_act && (wb_rd == in_rd);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
  assign byp_rd = 1'b0;
`endif

  // pend[0] is never set, so index 0 cannot stall
  assign busy_rs = pend[in_rs] && !byp_rs;
  assign busy_rt = pend[in_rt] && !byp_rt;
  assign busy_rd = pend[in_rd] && !byp_rd;
  assign haz     = busy_rs || busy_rt || busy_rd;

  assign in_ready = (!vld_q || out_ready) && !haz;
  assign accept   = in_valid && in_ready;

  always_comb begin
    iss_d      = iss_q;
    iss_d.func = in_func;
    iss_d.rd   = in_rd;
    iss_d.a    = (in_rs == '0) ? '0 : (byp_rs ? wb_data : rf[in_rs]);
    iss_d.b    = (in_rt == '0) ? '0 : (byp_rt ? wb_data : rf[in_rt]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      iss_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      iss_q <= iss_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // register file and scoreboard; a same-cycle set beats the write-back clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf   <= '0;
      pend <= '0;
    end else begin
      if (wb_act) begin
        rf[wb_rd]   <= wb_data;
        pend[wb_rd] <= 1'b0;
      end
      if (accept && (in_rd != '0))
        pend[in_rd] <= 1'b1;
    end
  end

  assign out_valid = vld_q;
  assign out_func  = iss_q.func;
  assign out_a     = iss_q.a;
  assign out_b     = iss_q.b;
  assign out_rd    = iss_q.rd;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, mid-hold reset sequence, random run vs. a cycle model.
module tb_operand_fetch;
  localparam int DW = 32, AW = 5, FW = 6;
  localparam bit BYP = 1'b0;

  logic          clk = 1'b0, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [FW-1:0] in_func, out_func;
  logic [AW-1:0] in_rs, in_rt, in_rd, out_rd, wb_rd;
  logic [DW-1:0] out_a, out_b, wb_data;

  operand_fetch #(.DATA_W(DW), .REG_AW(AW), .FUNC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data));

  always #5 clk = ~clk;

  typedef struct {
    bit v; logic [FW-1:0] func; logic [AW-1:0] rs, rt, rd;
    bit ordy, wbe; logic [AW-1:0] wbrd; logic [DW-1:0] wbd;
    bit er, ov; logic [FW-1:0] efunc; logic [DW-1:0] ea, eb; logic [AW-1:0] erd;
  } vec_t;

  int total = 0, bad = 0;

  // architectural model: register values, outstanding writes, output bundle
  logic [DW-1:0] mreg [32];
  bit            mpend[32];
  bit            mv;
  logic [FW-1:0] mf;
  logic [DW-1:0] ma, mb;
  logic [AW-1:0] mrd;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mreg[i] = '0; mpend[i] = 1'b0; end
    mv = 1'b0; mf = '0; ma = '0; mb = '0; mrd = '0;
  endtask

  function automatic bit fwd(input vec_t v, input logic [AW-1:0] i);
    return BYP && v.wbe && v.wbrd == i && i != 0;
  endfunction

  function automatic bit mbusy(input vec_t v, input logic [AW-1:0] i);
    return i != 0 && mpend[i] && !fwd(v, i);
  endfunction

  function automatic logic [DW-1:0] mread(input vec_t v, input logic [AW-1:0] i);
    if (i == 0) return '0;
    if (fwd(v, i)) return v.wbd;
    return mreg[i];
  endfunction

  function automatic vec_t mk(input bit v, input int func, rs, rt, rd, input bit ordy,
                              input bit wbe, input int wbrd, wbd,
                              input bit er, ov, input int efunc, ea, eb, erd);
    vec_t r;
    r.v = v; r.func = FW'(func); r.rs = AW'(rs); r.rt = AW'(rt); r.rd = AW'(rd);
    r.ordy = ordy; r.wbe = wbe; r.wbrd = AW'(wbrd); r.wbd = DW'(wbd);
    r.er = er; r.ov = ov; r.efunc = FW'(efunc); r.ea = DW'(ea); r.eb = DW'(eb); r.erd = AW'(erd);
    return r;
  endfunction

  // one clock: drive, check in_ready before the edge, check outputs after it
  task automatic apply(input vec_t v, input bit use_tab);
    bit er, acc;
    logic [DW-1:0] a, b;
    in_valid = v.v; in_func = v.func; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    out_ready = v.ordy; wb_en = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd;
    #1;
    er  = (!mv || v.ordy) && !mbusy(v, v.rs) && !mbusy(v, v.rt) && !mbusy(v, v.rd);
    acc = v.v && er;
    a = mread(v, v.rs);
    b = mread(v, v.rt);
    chk("in_ready", in_ready, use_tab ? v.er : er);
    if (acc) begin mv = 1'b1; mf = v.func; ma = a; mb = b; mrd = v.rd; end
    else if (v.ordy) mv = 1'b0;
    if (v.wbe && v.wbrd != 0) begin mreg[v.wbrd] = v.wbd; mpend[v.wbrd] = 1'b0; end
    if (acc && v.rd != 0) mpend[v.rd] = 1'b1;
    @(posedge clk); #1;
    chk("out_valid", out_valid, use_tab ? v.ov    : mv);
    chk("out_func",  out_func,  use_tab ? v.efunc : mf);
    chk("out_a",     out_a,     use_tab ? v.ea    : ma);
    chk("out_b",     out_b,     use_tab ? v.eb    : mb);
    chk("out_rd",    out_rd,    use_tab ? v.erd   : mrd);
  endtask

  vec_t tab[$];
  vec_t rv;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    out_ready = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_func", out_func, 0);
    chk("rst_in_ready", in_ready, 1);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    //          v func rs rt rd ordy wbe wbrd wbd  er ov ef ea  eb erd
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1,  5, 1, 0, 0,  0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2,  7, 1, 0, 0,  0, 0, 0));
    tab.push_back(mk(1, 0, 1, 2, 3, 1, 0, 0,  0, 1, 1, 0,  5, 7, 3));
    tab.push_back(mk(1, 1, 3, 0, 5, 1, 0, 0,  0, 0, 0, 0,  5, 7, 3));
    tab.push_back(mk(1, 1, 3, 0, 5, 1, 1, 3, 12, 0, 0, 0,  5, 7, 3));
    tab.push_back(mk(1, 1, 3, 0, 5, 1, 0, 0,  0, 1, 1, 1, 12, 0, 5));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(1, 2, 1, 2, 6, 0, 0, 0, 0, 0, 1, 1, 12, 0, 5));
    tab.push_back(mk(1, 2, 1, 2, 6, 1, 0, 0,  0, 1, 1, 2,  5, 7, 6));
    tab.push_back(mk(1, 3, 0, 0, 0, 1, 1, 0, 99, 1, 1, 3,  0, 0, 0));
    tab.push_back(mk(1, 4, 0, 1, 0, 1, 0, 0,  0, 1, 1, 4,  0, 5, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 6, 33, 1, 0, 4,  0, 5, 0));
    tab.push_back(mk(1, 5, 1, 0, 6, 1, 1, 6, 44, 1, 1, 5,  5, 0, 6));
    tab.push_back(mk(1, 6, 6, 0, 7, 1, 0, 0,  0, 0, 0, 5,  5, 0, 6));
    tab.push_back(mk(1, 6, 6, 0, 7, 1, 1, 6, 50, 0, 0, 5,  5, 0, 6));
    tab.push_back(mk(1, 6, 6, 0, 7, 1, 0, 0,  0, 1, 1, 6, 50, 0, 7));
    foreach (tab[i]) apply(tab[i], 1'b1);

    // reset while a bundle is held and rd=4 is outstanding
    apply(mk(1, 3, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    apply(mk(1, 2, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_rd", out_rd, 0);
    chk("midrst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(1, 5, 4, 1, 8, 1, 0, 0, 0, 1, 1, 5, 0, 0, 8), 1'b1);
    apply(mk(1, 1, 8, 0, 2, 1, 0, 0, 0, 0, 0, 5, 0, 0, 8), 1'b1);

    for (int n = 0; n < 600; n++) begin
      rv = mk($urandom_range(0, 3) != 0, $urandom_range(0, 63),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7), $urandom, 0, 0, 0, 0, 0, 0);
      apply(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch and issue stage sitting directly upstream of the ALU. It holds the 32-entry general register file. It accepts decoded operations over a valid/ready handshake, reads both source operands and presents a registered `{func, A, B, rd}` bundle to the ALU. A per-register pending scoreboard stalls any operation whose sources or destination are still awaiting write-back. ALU results return through the write-back port and update the register file.

## Interface
- `DATA_W`, 32, operand/result width (ALU A/B/out width)
- `REG_AW`, 5, register address width; register count = 2**REG_AW
- `FUNC_W`, 6, ALU function code width, passed through unmodified
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded op present
- `in_ready`  out  1  stage can accept op this cycle
- `in_func`  in  FUNC_W  ALU function code
- `in_rs`, `in_rt`  in  REG_AW  source register indices (A, B)
- `in_rd`  in  REG_AW  destination register index
- `out_valid`  out  1  issued bundle valid to ALU
- `out_ready`  in  1  ALU/next stage consumes bundle
- `out_func`  out  FUNC_W  registered function code
- `out_a`, `out_b`  out  DATA_W  registered operands
- `out_rd`  out  REG_AW  registered destination index
- `wb_en`  in  1  write-back strobe
- `wb_rd`  in  REG_AW  write-back register index
- `wb_data`  in  DATA_W  write-back value (ALU `out`)

## Operation
- Register 0 always reads 0. Writes to it are discarded. It is never marked pending.
- Write-back: on `wb_en` with `wb_rd != 0`, the register takes `wb_data` at the edge and `pending[wb_rd]` clears.
- Hazard (`haz`): `pending[in_rs]`, `pending[in_rt]` or `pending[in_rd]` is set for a nonzero index. A pending bit cleared by a same-cycle write-back does not count, subject to Configuration.
- `in_ready = (!out_valid || out_ready) && !haz`. The handshake is combinational on inputs.
- Accept (`in_valid && in_ready`):
  - `out_func`, `out_rd` and operands are captured, with `out_a` taken from `rs` and `out_b` from `rt`.
  - `out_valid` is set.
  - If `in_rd != 0`, `pending[in_rd]` is set.
- If a write-back and a set hit the same register in the same cycle, the set wins.
- Output hold: while `out_valid && !out_ready`, all `out_*` stay stable.
- Drain: `out_ready && !accept` clears `out_valid`. The `out_*` data fields keep their last value.
- Write-back ordering is in-order and external. The block never generates `wb_*`.
- WAW is avoided by the `pending[in_rd]` check. At most one write is outstanding per register.

## Timing
- Reset (async, immediate):
  - `out_valid=0`, `out_func=0`, `out_a=0`, `out_b=0`, `out_rd=0`.
  - All registers = 0, all pending = 0.
  - `in_ready` follows from these values, so it is 1 after reset.
- Issue latency: 1 cycle. An op accepted at edge N is valid on `out_*` after edge N.
- Throughput: 1 op/cycle when `out_ready=1` and there are no hazards.
- Write-back at edge N is visible to reads in the cycle after N, and earlier with bypass.
- Reset asserted mid-operation discards the in-flight bundle and all pending bits.

## Configuration
- `WB_BYPASS_EN` defined:
  - A same-cycle `wb_en` to a source register forwards `wb_data` into the captured operand.
  - The matching pending bit does not count as a hazard.
  - Result: zero bubble after write-back.
- `WB_BYPASS_EN` undefined:
  - Operands read only from the array, so the old value is read.
  - Any set pending bit is a hazard, even if it is being cleared this cycle.
  - Result: one extra stall cycle after write-back.

## Test plan
- Reset, then write r1=5 and r2=7 via wb. Issue func=0, rs=1, rt=2, rd=3 -> next cycle `out_valid=1`, `out_a=5`, `out_b=7`, `out_rd=3`, and `in_ready` stays 1.
- Issue rd=3, then rs=3 next cycle -> `in_ready=0` until wb_rd=3 with wb_data=12. With `WB_BYPASS_EN`, the op is accepted in the wb cycle with `out_a=12`. Without it, the op is accepted one cycle later, also with `out_a=12`.
- Hold `out_ready=0` with an op in the output register and a new op valid -> `in_ready=0`, and `out_*` is unchanged for 4 cycles. Raising `out_ready` -> the new op is accepted the same cycle.
- Issue an op with rd=0, and write back r0=99 -> no pending bit is set, a read of r0 returns 0, and there is no stall.
- Issue rd=4, assert `rst_n=0` mid-hold, then release -> `out_valid=0`, all registers 0, and an op with rs=4 is accepted immediately.
- Same-cycle wb_rd=6 and accept of a new op with rd=6 after a prior rd=6 has cleared -> `pending[6]` stays set, and a following rs=6 stalls.
